instruction_fetch_hardware: RTL and testbench

Instruction-fetch stage of the single-cycle MIPS datapath. Holds the program counter (PC), advances it by 4 bytes every clock, and reads the 32-bit instruction at the current PC from an internal read-only instruction memory. pc_out is a byte offset into instruction memory. The virtual fetch address, formed downstream, is pc_out + 0x0040_0000 (MIPS text-segment base).

---
 rtl/mips_pkg.sv | 10 +
 rtl/instruction_memory.sv | 30 +++
 rtl/instruction_fetch_hardware.sv | 45 ++++
 tb/tb_instruction_fetch_hardware.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS constants for the fetch stage: text-segment base, word width,
// PC stride and the canonical nop encoding.
package mips_pkg;

  localparam int unsigned     INSTR_W   = 32;
  localparam logic [31:0]     TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0]     PC_INCR   = 32'd4;
  localparam logic [INSTR_W-1:0] NOP    = 32'h0000_0000;

endpackage : mips_pkg

// File: rtl/instruction_memory.sv
// Read-only instruction store: a fixed startup program followed by nops.
// Purely combinational, so the word is valid in the same cycle as its address.
module instruction_memory
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic [$clog2(MEM_WORDS)-1:0] i_addr,
  output logic [INSTR_W-1:0]           o_data
);

  localparam int AW = $clog2(MEM_WORDS);

  // NOTE: every path assigns o_data (default first), so no latch is inferred.
  always_comb begin
    o_data = NOP;
    case (i_addr)
      AW'(0): o_data = 32'h2008_0005;  // addi $t0,$zero,5
      AW'(1): o_data = 32'h2009_0003;  // addi $t1,$zero,3
      AW'(2): o_data = 32'h0109_5020;  // add  $t2,$t0,$t1
      AW'(3): o_data = 32'h0109_5822;  // sub  $t3,$t0,$t1
      AW'(4): o_data = 32'h0109_6024;  // and  $t4,$t0,$t1
      AW'(5): o_data = 32'h0109_6825;  // or   $t5,$t0,$t1
      AW'(6): o_data = 32'hAC0A_0000;  // sw   $t2,0($zero)
      AW'(7): o_data = 32'h8C0E_0000;  // lw   $t6,0($zero)
      default: o_data = NOP;
    endcase
  end

endmodule : instruction_memory

// File: rtl/instruction_fetch_hardware.sv
// Fetch stage: program counter that advances one word per clock and wraps at
// the end of instruction memory, plus the zero-latency instruction read.
module instruction_fetch_hardware
  import mips_pkg::*;
#(
  parameter int          MEM_WORDS = 64,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic [INSTR_W-1:0] instruction,
  output logic [31:0]        pc_out
);

  localparam int          AW      = $clog2(MEM_WORDS);
  localparam logic [31:0] LAST_PC = 32'((MEM_WORDS - 1) * 4);

  logic [31:0]   r_pc;
  logic [31:0]   w_pc_next;
  logic [AW-1:0] w_word_addr;

  // Wrap back to offset 0 after the last word rather than running past the ROM.
  assign w_pc_next = (r_pc == LAST_PC) ? 32'h0 : r_pc + PC_INCR;

  // NOTE: state updates use non-blocking assignment; the async branch makes
  // pc_out follow reset immediately, with no clock edge needed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign w_word_addr = r_pc[AW+1:2];
  assign pc_out      = r_pc;

  instruction_memory #(
    .MEM_WORDS (MEM_WORDS)
  ) u_imem (
    .i_addr (w_word_addr),
    .o_data (instruction)
  );

endmodule : instruction_fetch_hardware

// File: tb/tb_instruction_fetch_hardware.sv
// Self-checking bench for the fetch stage: directed reset/fetch/wrap steps,
// then a randomized run with reset pulses against an arithmetic PC model.
module tb_instruction_fetch_hardware;

  localparam int          MEM_WORDS = 64;
  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [31:0] pc_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model_pc;

  instruction_fetch_hardware #(
    .MEM_WORDS (MEM_WORDS),
    .RESET_PC  (RESET_PC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .instruction (instruction),
    .pc_out      (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] rom_model(input logic [31:0] byte_off);
    logic [31:0] prog [8];
    int idx;
    prog = '{32'h2008_0005, 32'h2009_0003, 32'h0109_5020, 32'h0109_5822,
             32'h0109_6024, 32'h0109_6825, 32'hAC0A_0000, 32'h8C0E_0000};
    idx = int'(byte_off / 4);
    return (idx < 8) ? prog[idx] : 32'h0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge; model advances by a word modulo the memory size.
  task automatic step();
    @(posedge clk);
    if (reset) model_pc = (model_pc + 32'd4) % (MEM_WORDS * 4);
    else       model_pc = RESET_PC;
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"},    pc_out,      model_pc);
    check({tag, "_instr"}, instruction, rom_model(model_pc));
  endtask

  initial begin
    logic [31:0] exp_pc [5];
    logic [31:0] exp_in [5];
    exp_pc = '{32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
    exp_in = '{32'h2009_0003, 32'h0109_5020, 32'h0109_5822, 32'h0109_6024, 32'h0109_6825};

    // Reset with no clock edge.
    reset    = 1'b0;
    model_pc = RESET_PC;
    #1;
    check("reset_pc",    pc_out,             32'h0000_0000);
    check("reset_instr", instruction,        32'h2008_0005);
    check("reset_virt",  pc_out + TEXT_BASE, 32'h0040_0000);

    // Sequential fetch.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("seq%0d_pc", i + 1),    pc_out,             exp_pc[i]);
      check($sformatf("seq%0d_instr", i + 1), instruction,        exp_in[i]);
      check($sformatf("seq%0d_virt", i + 1),  pc_out + TEXT_BASE, 32'h0040_0000 + exp_pc[i]);
    end

    // Rest of the program and into the nop region.
    step();
    check("edge6_instr", instruction, 32'hAC0A_0000);
    step();
    check("edge7_pc",    pc_out,      32'h0000_001C);
    check("edge7_instr", instruction, 32'h8C0E_0000);
    step();
    check("edge8_pc",    pc_out,      32'h0000_0020);
    check("edge8_instr", instruction, 32'h0000_0000);

    // Wrap-around.
    for (int i = 9; i <= 63; i++) step();
    check("edge63_pc",    pc_out,      32'h0000_00FC);
    check("edge63_instr", instruction, 32'h0000_0000);
    step();
    check("wrap_pc",    pc_out,      32'h0000_0000);
    check("wrap_instr", instruction, 32'h2008_0005);

    // Asynchronous reset mid-run, asserted away from the falling edge.
    for (int i = 0; i < 4; i++) step();
    check("pre_async_pc", pc_out, 32'h0000_0010);
    #2;
    reset    = 1'b0;
    model_pc = RESET_PC;
    #1;
    check("async_pc",    pc_out,      32'h0000_0000);
    check("async_instr", instruction, 32'h2008_0005);
    step();
    check("hold1_pc", pc_out, 32'h0000_0000);
    step();
    check("hold2_pc", pc_out, 32'h0000_0000);
    @(negedge clk);
    reset = 1'b1;
    step();
    check("release_pc",    pc_out,      32'h0000_0004);
    check("release_instr", instruction, 32'h2009_0003);

    // Randomized run with random reset pulses.
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ($urandom_range(9) == 0) begin
        #($urandom_range(3));
        reset    = 1'b0;
        model_pc = RESET_PC;
        #1;
        check($sformatf("rnd%0d_async_pc", i), pc_out, RESET_PC);
      end else begin
        reset = 1'b1;
      end
      step();
      check($sformatf("rnd%0d_align", i), {30'h0, pc_out[1:0]}, 32'h0);
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_instruction_fetch_hardware
